// File: rtl/audio_frame_buffer.sv
// Ping-pong PCM frame buffer. Samples arrive one per rising edge of the
// decimator's dv level and are packed into FRAME_LEN-sample frames. Each
// completed frame is held for the consumer together with its sum of |x|.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no frame held; frame_rdy low
// FULL  | frame in frame_bank held for the consumer until frame_ack
module audio_frame_buffer #(
   parameter int DW        = 16,
   parameter int FRAME_LEN = 256,
   parameter int AW        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dv,
   input  logic [DW-1:0]    dat_i,
   output logic             frame_rdy,
   output logic             frame_bank,
   output logic [DW+AW-1:0] energy,
   input  logic [AW-1:0]    rd_addr,
   output logic [DW-1:0]    rd_dat,
   input  logic             frame_ack,
   input  logic             ovr_clr,
   output logic             overrun
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [AW-1:0] LAST_PTR = AW'(FRAME_LEN - 1);

   state_t             state_q;
   state_t             state_d;
   logic               dv_d;
   logic               wr_bank;
   logic [AW-1:0]      wr_ptr;
   logic [DW+AW-1:0]   acc;
   logic               stb;
   logic               complete;
   logic [DW-1:0]      mag;
   logic [DW+AW-1:0]   acc_sum;
   logic               accept;
   logic               drop;

   logic [DW-1:0]      mem [0:2*FRAME_LEN-1];

   // Rising edge of dv; dv_d resets high so a dv held through reset is ignored.
   assign stb      = dv & ~dv_d;
   assign complete = stb && (wr_ptr == LAST_PTR);
   // Magnitude in DW unsigned bits; the most negative value maps to 2^(DW-1).
   assign mag      = dat_i[DW-1] ? (~dat_i + 1'b1) : dat_i;
   assign acc_sum  = acc + {{AW{1'b0}}, mag};
   assign frame_rdy = (state_q == FULL);

   // Next-state logic: ack is honoured before a simultaneous completion.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      drop    = 1'b0;
      case (state_q)
         EMPTY: begin
            if (complete) begin
               state_d = FULL;
               accept  = 1'b1;
            end
         end
         FULL: begin
            if (complete) begin
               if (frame_ack) accept = 1'b1;
               else           drop   = 1'b1;
            end else if (frame_ack) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // State register, write pointer, accumulator and held-frame outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= EMPTY;
         dv_d       <= 1'b1;
         wr_bank    <= 1'b0;
         wr_ptr     <= '0;
         acc        <= '0;
         frame_bank <= 1'b0;
         energy     <= '0;
         overrun    <= 1'b0;
      end else begin
         state_q <= state_d;
         dv_d    <= dv;
         if (stb) begin
            wr_ptr <= wr_ptr + 1'b1;
            acc    <= complete ? '0 : acc_sum;
         end
         if (accept) begin
            frame_bank <= wr_bank;
            energy     <= acc_sum;
            wr_bank    <= ~wr_bank;
         end
         if (drop)         overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

   // Sample RAM write port; no writes while reset is asserted.
   always_ff @(posedge clk) begin
      if (reset && stb) mem[{wr_bank, wr_ptr}] <= dat_i;
   end

   // Registered read port of the held bank.
   always_ff @(posedge clk) begin
      if (!reset) rd_dat <= '0;
      else        rd_dat <= mem[{frame_bank, rd_addr}];
   end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer: frame packing, energy, ping-pong
// banking, overrun and reset behaviour.
module tb_audio_frame_buffer;

   localparam int DW = 16;
   localparam int AW = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             dv;
   logic [DW-1:0]    dat_i;
   logic             frame_rdy;
   logic             frame_bank;
   logic [DW+AW-1:0] energy;
   logic [AW-1:0]    rd_addr;
   logic [DW-1:0]    rd_dat;
   logic             frame_ack;
   logic             ovr_clr;
   logic             overrun;

   int n_vec = 0;
   int n_err = 0;

   audio_frame_buffer #(.DW(DW), .FRAME_LEN(256), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .dv         (dv),
      .dat_i      (dat_i),
      .frame_rdy  (frame_rdy),
      .frame_bank (frame_bank),
      .energy     (energy),
      .rd_addr    (rd_addr),
      .rd_dat     (rd_dat),
      .frame_ack  (frame_ack),
      .ovr_clr    (ovr_clr),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // one-cycle dv pulse; inputs change on negedge, DUT samples on posedge
   task automatic pulse(input logic [DW-1:0] d);
      @(negedge clk);
      dv    = 1'b1;
      dat_i = d;
      @(negedge clk);
      dv    = 1'b0;
   endtask

   task automatic pulses(input int n, input logic [DW-1:0] d);
      for (int i = 0; i < n; i++) pulse(d);
   endtask

   task automatic read_word(input logic [AW-1:0] a);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         dv    = ~dv;
         dat_i = 16'hAAAA;
      end
      n_vec++; if (frame_rdy !== 1'b0) begin n_err++; $display("FAIL rst_frame_rdy: got %0b want 0", frame_rdy); end
      n_vec++; if (frame_bank !== 1'b0) begin n_err++; $display("FAIL rst_frame_bank: got %0b want 0", frame_bank); end
      n_vec++; if (energy !== 24'd0) begin n_err++; $display("FAIL rst_energy: got %0d want 0", energy); end
      n_vec++; if (rd_dat !== 16'd0) begin n_err++; $display("FAIL rst_rd_dat: got %0h want 0", rd_dat); end
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
      // release with dv held high: must not count as a sample
      @(negedge clk);
      dv    = 1'b1;
      dat_i = 16'h1234;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      dv = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame;
      for (int k = 0; k < 255; k++) pulse(DW'(k));
      n_vec++; if (frame_rdy !== 1'b0) begin n_err++; $display("FAIL frame_early: got %0b want 0", frame_rdy); end
      @(negedge clk);
      dv    = 1'b1;
      dat_i = 16'd255;
      @(posedge clk); #1;
      n_vec++; if (frame_rdy !== 1'b1) begin n_err++; $display("FAIL frame_latency: got %0b want 1", frame_rdy); end
      @(negedge clk);
      dv = 1'b0;
      n_vec++; if (frame_bank !== 1'b0) begin n_err++; $display("FAIL frame_bank0: got %0b want 0", frame_bank); end
      n_vec++; if (energy !== 24'd32640) begin n_err++; $display("FAIL frame_energy: got %0d want 32640", energy); end
      read_word(8'd5);
      n_vec++; if (rd_dat !== 16'd5) begin n_err++; $display("FAIL frame_rd5: got %0h want 5", rd_dat); end
      read_word(8'd255);
      n_vec++; if (rd_dat !== 16'd255) begin n_err++; $display("FAIL frame_rd255: got %0h want ff", rd_dat); end
   endtask

   task automatic test_ack_min_neg;
      @(negedge clk);
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
      n_vec++; if (frame_rdy !== 1'b0) begin n_err++; $display("FAIL ack_clear: got %0b want 0", frame_rdy); end
      n_vec++; if (energy !== 24'd32640) begin n_err++; $display("FAIL ack_energy_hold: got %0d want 32640", energy); end
      // first sample: dv held for 10 cycles
      @(negedge clk);
      dv    = 1'b1;
      dat_i = 16'h8000;
      repeat (10) @(negedge clk);
      dv = 1'b0;
      pulses(254, 16'h8000);
      n_vec++; if (frame_rdy !== 1'b0) begin n_err++; $display("FAIL long_dv_once: got %0b want 0", frame_rdy); end
      pulse(16'h8000);
      n_vec++; if (frame_rdy !== 1'b1) begin n_err++; $display("FAIL neg_rdy: got %0b want 1", frame_rdy); end
      n_vec++; if (frame_bank !== 1'b1) begin n_err++; $display("FAIL neg_bank1: got %0b want 1", frame_bank); end
      n_vec++; if (energy !== 24'd8388608) begin n_err++; $display("FAIL neg_energy: got %0d want 8388608", energy); end
      read_word(8'd7);
      n_vec++; if (rd_dat !== 16'h8000) begin n_err++; $display("FAIL neg_rd7: got %0h want 8000", rd_dat); end
   endtask

   task automatic test_overrun;
      pulses(256, 16'd3);
      n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b want 1", overrun); end
      n_vec++; if (frame_rdy !== 1'b1) begin n_err++; $display("FAIL ovr_rdy: got %0b want 1", frame_rdy); end
      n_vec++; if (frame_bank !== 1'b1) begin n_err++; $display("FAIL ovr_bank: got %0b want 1", frame_bank); end
      n_vec++; if (energy !== 24'd8388608) begin n_err++; $display("FAIL ovr_energy: got %0d want 8388608", energy); end
      read_word(8'd200);
      n_vec++; if (rd_dat !== 16'h8000) begin n_err++; $display("FAIL ovr_data: got %0h want 8000", rd_dat); end
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %0b want 0", overrun); end
   endtask

   task automatic test_ack_on_complete;
      pulses(255, 16'd2);
      @(negedge clk);
      dv        = 1'b1;
      dat_i     = 16'hFFFE;
      frame_ack = 1'b1;
      @(negedge clk);
      dv        = 1'b0;
      frame_ack = 1'b0;
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ackc_overrun: got %0b want 0", overrun); end
      n_vec++; if (frame_rdy !== 1'b1) begin n_err++; $display("FAIL ackc_rdy: got %0b want 1", frame_rdy); end
      n_vec++; if (frame_bank !== 1'b0) begin n_err++; $display("FAIL ackc_bank: got %0b want 0", frame_bank); end
      n_vec++; if (energy !== 24'd512) begin n_err++; $display("FAIL ackc_energy: got %0d want 512", energy); end
      read_word(8'd255);
      n_vec++; if (rd_dat !== 16'hFFFE) begin n_err++; $display("FAIL ackc_rd255: got %0h want fffe", rd_dat); end
   endtask

   task automatic test_reset_midframe;
      pulses(100, 16'd7);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      n_vec++; if (frame_rdy !== 1'b0) begin n_err++; $display("FAIL mid_rst_rdy: got %0b want 0", frame_rdy); end
      n_vec++; if (energy !== 24'd0) begin n_err++; $display("FAIL mid_rst_energy: got %0d want 0", energy); end
      pulses(255, 16'd1);
      n_vec++; if (frame_rdy !== 1'b0) begin n_err++; $display("FAIL mid_partial: got %0b want 0", frame_rdy); end
      pulse(16'd1);
      n_vec++; if (frame_rdy !== 1'b1) begin n_err++; $display("FAIL mid_rdy: got %0b want 1", frame_rdy); end
      n_vec++; if (frame_bank !== 1'b0) begin n_err++; $display("FAIL mid_bank: got %0b want 0", frame_bank); end
      n_vec++; if (energy !== 24'd256) begin n_err++; $display("FAIL mid_energy: got %0d want 256", energy); end
   endtask

   initial begin
      reset     = 1'b0;
      dv        = 1'b0;
      dat_i     = '0;
      rd_addr   = '0;
      frame_ack = 1'b0;
      ovr_clr   = 1'b0;
      test_reset();
      test_frame();
      test_ack_min_neg();
      test_overrun();
      test_ack_on_complete();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
